// File: rtl/rom_sp_arb.sv
// rom_sp_arb -- round-robin read arbiter sharing one rom_sp read port.
//
// Grants at most one pending request per cycle and drives the ROM enable and
// address. A small tracking pipe follows each read through the fixed ROM
// latency. It routes the returning word to its owner with a one-hot valid.
//
// Handshake: a request on slot i is accepted on the rising edge where
// req_valid_i[i] & req_ready_o[i] are both 1. req_ready_o is a one-hot grant
// that depends only on req_valid_i and the round-robin pointer, never on
// response state. Responses are not held: rsp_valid_o pulses for exactly one
// cycle and the requester must take rsp_data_o in that cycle.
//
// Ports:
//   clk_i          clock, shared with the rom_sp read clock
//   rst_i          asynchronous, active-high reset
//   req_valid_i    per-requester read request
//   req_addr_i     packed request addresses, slice i belongs to requester i
//   req_ready_o    one-hot grant
//   rsp_valid_o    one-hot response valid
//   rsp_data_o     shared response data (don't-care when rsp_valid_o == 0)
//   rom_rd_en_o    rom_sp read enable
//   rom_rd_addr_o  rom_sp read address
//   rom_rd_data_i  rom_sp read data
//   busy_o         high while any read is in flight
module rom_sp_arb #(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 65536,
    parameter int REG_OUT = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    input  logic [N_REQ*$clog2(DEPTH)-1:0] req_addr_i,
    output logic [N_REQ-1:0]               req_ready_o,
    output logic [N_REQ-1:0]               rsp_valid_o,
    output logic [D_WIDTH-1:0]             rsp_data_o,
    output logic                           rom_rd_en_o,
    output logic [$clog2(DEPTH)-1:0]       rom_rd_addr_o,
    input  logic [D_WIDTH-1:0]             rom_rd_data_i,
    output logic                           busy_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT = 1 + REG_OUT;

    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   grant_idx;
    logic [N_REQ-1:0] grant;
    logic             found;
    logic [IDW-1:0]   cand;

    logic [LAT-1:0]   trk_vld;
    logic [IDW-1:0]   trk_id [LAT];

    // Search starts one past the last winner and wraps, so the last winner has
    // lowest priority on the next cycle.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % N_REQ);
            if (!found && req_valid_i[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign req_ready_o   = grant;
    assign rom_rd_en_o   = |req_valid_i;
    assign rom_rd_addr_o = rom_rd_en_o ? req_addr_i[int'(grant_idx)*AW +: AW] : '0;

    // Pointer and tracking pipe. Reset drops all in-flight reads and parks
    // the pointer on the last slot so requester 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q  <= IDW'(N_REQ - 1);
            trk_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                trk_id[s] <= '0;
            end
        end else begin
            if (rom_rd_en_o) begin
                last_q <= grant_idx;
            end
            trk_vld[0] <= rom_rd_en_o;
            trk_id[0]  <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                trk_vld[s] <= trk_vld[s-1];
                trk_id[s]  <= trk_id[s-1];
            end
        end
    end

    // The last tracking stage lines up with the ROM output word.
    always_comb begin
        rsp_valid_o = '0;
        if (trk_vld[LAT-1]) begin
            rsp_valid_o[trk_id[LAT-1]] = 1'b1;
        end
    end

    assign rsp_data_o = rom_rd_data_i;
    assign busy_o     = |trk_vld;

endmodule

// File: tb/tb_rom_sp_arb.sv
// tb_rom_sp_arb -- directed bench for rom_sp_arb.
// Two instances share one stimulus: REG_OUT=1 (r1_*) and REG_OUT=0 (r0_*).
// Each has its own behavioural ROM holding word[a] = a.
module tb_rom_sp_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int W  = 32 + N + DW;   // {due cycle, one-hot owner, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;

    logic [N-1:0]  r1_ready, r1_rsp_valid, r0_ready, r0_rsp_valid;
    logic [DW-1:0] r1_rsp_data, r0_rsp_data, r1_rom_data, r0_rom_data;
    logic          r1_en, r0_en, r1_busy, r0_busy;
    logic [AW-1:0] r1_addr, r0_addr;

    rom_sp_arb #(.N_REQ(N), .D_WIDTH(DW), .DEPTH(65536), .REG_OUT(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(r1_ready), .rsp_valid_o(r1_rsp_valid), .rsp_data_o(r1_rsp_data),
        .rom_rd_en_o(r1_en), .rom_rd_addr_o(r1_addr), .rom_rd_data_i(r1_rom_data),
        .busy_o(r1_busy)
    );

    rom_sp_arb #(.N_REQ(N), .D_WIDTH(DW), .DEPTH(65536), .REG_OUT(0)) dut_r0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_ready_o(r0_ready), .rsp_valid_o(r0_rsp_valid), .rsp_data_o(r0_rsp_data),
        .rom_rd_en_o(r0_en), .rom_rd_addr_o(r0_addr), .rom_rd_data_i(r0_rom_data),
        .busy_o(r0_busy)
    );

    // ROM models: word[a] = a, latency 2 (registered output) and 1.
    logic [AW-1:0] rom1_a1, rom1_a2, rom0_a1;
    always @(posedge clk) begin
        if (r1_en) rom1_a1 <= r1_addr;
        rom1_a2 <= rom1_a1;
        if (r0_en) rom0_a1 <= r0_addr;
    end
    assign r1_rom_data = {16'h0, rom1_a2};
    assign r0_rom_data = {16'h0, rom0_a1};

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] v, input logic [AW-1:0] a0, a1, a2, a3);
        req_valid = v;
        req_addr  = {a3, a2, a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        drive(4'b0000, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    // Reference arbiter: indices above the last winner first, then the rest.
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] e;
    int           cyc = 0;
    int           m_last = N - 1;
    int           m_gidx;
    logic [N-1:0] m_ready;
    logic [AW-1:0] m_addr;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_last = N - 1;
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            if (r1_rsp_valid != 0 || (exp_q1.size() > 0 && exp_q1[0][W-1 -: 32] == 32'(cyc))) begin
                if (exp_q1.size() == 0) begin
                    chk("r1_unexpected_rsp", r1_rsp_valid, 0);
                end else begin
                    e = exp_q1.pop_front();
                    chk("r1_rsp_valid", r1_rsp_valid, e[DW+N-1:DW]);
                    chk("r1_rsp_data", r1_rsp_data, e[DW-1:0]);
                    chk("r1_rsp_cycle", cyc, e[W-1 -: 32]);
                end
            end
            if (r0_rsp_valid != 0 || (exp_q0.size() > 0 && exp_q0[0][W-1 -: 32] == 32'(cyc))) begin
                if (exp_q0.size() == 0) begin
                    chk("r0_unexpected_rsp", r0_rsp_valid, 0);
                end else begin
                    e = exp_q0.pop_front();
                    chk("r0_rsp_valid", r0_rsp_valid, e[DW+N-1:DW]);
                    chk("r0_rsp_data", r0_rsp_data, e[DW-1:0]);
                    chk("r0_rsp_cycle", cyc, e[W-1 -: 32]);
                end
            end

            m_gidx = -1;
            for (int i = m_last + 1; i < N; i++)
                if (m_gidx < 0 && req_valid[i]) m_gidx = i;
            for (int i = 0; i <= m_last; i++)
                if (m_gidx < 0 && req_valid[i]) m_gidx = i;
            m_ready = (m_gidx >= 0) ? N'(1 << m_gidx) : '0;
            chk("r1_arb_ready", r1_ready, m_ready);
            chk("r0_arb_ready", r0_ready, m_ready);
            if (m_gidx >= 0) begin
                m_addr = req_addr[m_gidx*AW +: AW];
                chk("r1_rom_addr", r1_addr, m_addr);
                exp_q1.push_back({32'(cyc + 2), m_ready, 16'h0, m_addr});
                exp_q0.push_back({32'(cyc + 1), m_ready, 16'h0, m_addr});
                m_last = m_gidx;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        drive(4'b0000, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", r1_rsp_valid, 0);
        chk("reset_busy", r1_busy, 0);
        chk("reset_ready", r1_ready, 0);
        chk("reset_rom_en", r1_en, 0);
        chk("reset_r0_busy", r0_busy, 0);
        next_cycle();
        rst = 1'b0;

        // Single request from requester 2.
        drive(4'b0100, 0, 0, 16'h0010, 0);
        @(negedge clk);
        chk("single_ready", r1_ready, 4'b0100);
        chk("single_rom_en", r1_en, 1);
        chk("single_rom_addr", r1_addr, 16'h0010);
        chk("single_busy_c0", r1_busy, 0);
        next_cycle();
        drive(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("single_busy_c1", r1_busy, 1);
        chk("single_rsp_c1", r1_rsp_valid, 0);
        chk("single_r0_rsp", r0_rsp_valid, 4'b0100);
        chk("single_r0_data", r0_rsp_data, 32'h10);
        chk("single_rom_en_idle", r1_en, 0);
        next_cycle();
        @(negedge clk);
        chk("single_busy_c2", r1_busy, 1);
        chk("single_rsp_c2", r1_rsp_valid, 4'b0100);
        chk("single_data_c2", r1_rsp_data, 32'h10);
        next_cycle();
        @(negedge clk);
        chk("single_busy_c3", r1_busy, 0);
        chk("single_rsp_c3", r1_rsp_valid, 0);

        // All four valid for eight cycles right after reset.
        do_reset();
        drive(4'b1111, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("all_grant", r1_ready, 4'b0001 << (i % 4));
            if (i >= 2) chk("all_r1_data", r1_rsp_data, 32'h100 + 32'((i - 2) % 4));
            if (i >= 1) chk("all_r0_data", r0_rsp_data, 32'h100 + 32'((i - 1) % 4));
            next_cycle();
        end
        drive(4'b0000, 0, 0, 0, 0);
        repeat (3) next_cycle();

        // Fairness between 0 and 3, then requester 1 joins.
        drive(4'b1001, 16'h0200, 0, 0, 16'h0203);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fair_grant", r1_ready, (i % 2 == 0) ? 4'b0001 : 4'b1000);
            next_cycle();
        end
        drive(4'b1011, 16'h0200, 16'h0201, 0, 16'h0203);
        @(negedge clk);
        chk("join_grant0", r1_ready, 4'b0001);
        next_cycle();
        @(negedge clk);
        chk("join_grant1", r1_ready, 4'b0010);
        next_cycle();
        @(negedge clk);
        chk("join_grant3", r1_ready, 4'b1000);
        next_cycle();
        drive(4'b0000, 0, 0, 0, 0);
        repeat (3) next_cycle();

        // Address boundaries from requester 1.
        drive(4'b0010, 0, 16'hFFFF, 0, 0);
        @(negedge clk);
        chk("bound_addr_max", r1_addr, 16'hFFFF);
        next_cycle();
        drive(4'b0010, 0, 16'h0000, 0, 0);
        @(negedge clk);
        chk("bound_addr_zero", r1_addr, 16'h0000);
        next_cycle();
        drive(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("bound_rsp_max", r1_rsp_valid, 4'b0010);
        chk("bound_data_max", r1_rsp_data, 32'hFFFF);
        next_cycle();
        @(negedge clk);
        chk("bound_rsp_zero", r1_rsp_valid, 4'b0010);
        chk("bound_data_zero", r1_rsp_data, 32'h0);
        repeat (3) next_cycle();

        // Reset while a read is in flight.
        drive(4'b0001, 16'h0055, 0, 0, 0);
        @(negedge clk);
        chk("midrst_issue", r1_ready, 4'b0001);
        next_cycle();
        drive(4'b0000, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_a", r1_rsp_valid, 0);
        chk("midrst_busy_a", r1_busy, 0);
        next_cycle();
        @(negedge clk);
        chk("midrst_rsp_b", r1_rsp_valid, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_c", r1_rsp_valid, 0);
        chk("midrst_busy_c", r1_busy, 0);
        next_cycle();
        drive(4'b1001, 16'h0300, 0, 0, 16'h0303);
        @(negedge clk);
        chk("midrst_first", r1_ready, 4'b0001);
        next_cycle();
        @(negedge clk);
        chk("midrst_second", r1_ready, 4'b1000);
        next_cycle();
        drive(4'b0000, 0, 0, 0, 0);
        repeat (4) next_cycle();

        chk("r1_queue_drained", exp_q1.size(), 0);
        chk("r0_queue_drained", exp_q0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
